reg_bank_sb: RTL
================

# reg_bank_sb

Eight-entry, 16-bit architectural register storage with a per-register pending-write scoreboard for the WISC pipeline. It holds register state, accepts one writeback per cycle, and drives the packed `regData` bus consumed directly by the downstream read-select mux. It also tracks in-flight writes reserved at decode and raises a read-hazard stall for the two source operands that the mux is selecting.

## Interface
Parameters:
- `WIDTH`, 16, register data width.
- `CNT_W`, 2, pending-counter width; max in-flight writes per register = 2^CNT_W−1.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `writeEn`  in  1  writeback strobe.
- `writeRegSel`  in  3  writeback destination.
- `writeData`  in  WIDTH  writeback value.
- `reserveEn`  in  1  decode reserves a destination (in-flight write issued).
- `reserveRegSel`  in  3  reserved destination.
- `read1RegSel`, `read2RegSel`  in  3 each  source selects (same values fed to the read mux).
- `read1Used`, `read2Used`  in  1 each  operand actually needed by the instruction.
- `regData`  out  WIDTH*8  packed register contents; reg n at bits [WIDTH*(n+1)-1 : WIDTH*n].
- `busy`  out  8  bit n = register n has ≥1 pending write.
- `hazardStall`  out  1  decode must stall this cycle.
- `sbErr`  out  1  sticky scoreboard overflow/underflow flag.

## Operation
- Storage: 8 × WIDTH flops; on posedge with `writeEn`, reg[`writeRegSel`] ← `writeData`. No hardwired-zero register.
- Pending counter per register, CNT_W bits, next value:
  - reserve only (this reg): +1; write only: −1; both or neither: unchanged.
  - Reserve at max without matching write: counter holds at max, `sbErr` set.
  - Write with counter 0 and no same-cycle reserve: counter stays 0, data still written, `sbErr` set.
- `busy[n]` = counter[n] ≠ 0 (registered state, not next state).
- `hazardStall` = (read1Used & pend(read1RegSel)) | (read2Used & pend(read2RegSel)), where pend(r) is defined under Configuration.
- `sbErr` is sticky; cleared only by reset.
- `reserveEn` and `writeEn` are independent; any combination of registers is legal in the same cycle.

## Timing
- Reset (async assert, sync-safe deassert expected at the top level): all registers 0, all counters 0, `busy`=0, `hazardStall`=0 (given used=0), `sbErr`=0. Reset mid-operation discards all pending reservations.
- Write latency: `regData` reflects a write the cycle after the capturing edge (bypass off) or combinationally in the write cycle (bypass on).
- Reserve latency: `busy` is set the cycle after the reserving edge. A reserve and a read of the same register in the same cycle do not stall (the reservation belongs to the current instruction).
- `hazardStall` is combinational from the select/used inputs and registered state, plus write inputs when bypass is on.

## Configuration
- `REGBANK_WRITE_BYPASS_EN` defined:
  - `regData` slice for `writeRegSel` is `writeData` while `writeEn`=1 (write-before-read).
  - pend(r) = busy[r] & ~(writeEn & writeRegSel==r & counter[r]==1), i.e. the final pending write landing this cycle clears the stall.
- Undefined: `regData` is pure flop output; pend(r) = busy[r]; reading the register being written stalls one more cycle.

## Structure
- Shared package/include: `REG0_SELECT`..`REG7_SELECT` encodings (same ones the read mux uses), `NUM_REGS`=8, select width 3, default `CNT_W`.
- One sub-module, `reg_pend_counter`: inc/dec/saturate logic producing count, nonzero flag, and per-register overflow/underflow pulses; instantiated 8×. Storage, bypass, and stall logic stay in the top level.

## Test plan
- Reset: drive writes, then assert `rst_n`=0 mid-cycle → `regData`=0, `busy`=8'h00, `sbErr`=0 immediately.
- Write R3=16'hBEEF → `regData[63:48]`=16'hBEEF next cycle (bypass off) or in the same cycle (bypass on); other slices unchanged.
- Reserve R5, next cycle read1RegSel=5 with read1Used=1 → `hazardStall`=1. Write R5 with read still presented → stall=1 (bypass off), 0 (bypass on). Cycle after → `busy[5]`=0, stall=0.
- Reserve R2 three times, then a fourth reserve → `busy[2]`=1, `sbErr`=1. Three writes to R2 → `busy[2]`=0, `sbErr` remains 1.
- Same-cycle reserve and write of R1 with count=1 → count stays 1, `busy[1]` stays 1, data updated.
- Write R4 with count 0 → R4 updated, `sbErr`=1. read2RegSel=4 with read2Used=0 while busy → `hazardStall`=0.

Source files
------------

// File: rtl/reg_bank_sb_pkg.sv
// -----------------------------------------------------------------------------
// reg_bank_sb_pkg
// Shared constants for the WISC register bank: register count, select width,
// default data/counter widths and the register select encodings. The same
// encodings drive the downstream read-select mux.
// Helper: sel_decode() turns a 3-bit register select into a one-hot vector.
// Optional feature macro used by the bank: REGBANK_WRITE_BYPASS_EN.
// -----------------------------------------------------------------------------
package reg_bank_sb_pkg;

  localparam int NUM_REGS  = 8;
  localparam int SEL_W     = 3;
  localparam int WIDTH_DEF = 16;
  localparam int CNT_W_DEF = 2;

  typedef enum logic [SEL_W-1:0] {
    REG0_SELECT = 3'd0,
    REG1_SELECT = 3'd1,
    REG2_SELECT = 3'd2,
    REG3_SELECT = 3'd3,
    REG4_SELECT = 3'd4,
    REG5_SELECT = 3'd5,
    REG6_SELECT = 3'd6,
    REG7_SELECT = 3'd7
  } reg_sel_e;

  // One-hot decode of a register select.
  function automatic logic [NUM_REGS-1:0] sel_decode(input logic [SEL_W-1:0] sel);
    logic [NUM_REGS-1:0] w_one;
    w_one = {{(NUM_REGS-1){1'b0}}, 1'b1};
    return w_one << sel;
  endfunction

endpackage : reg_bank_sb_pkg

// File: rtl/reg_bank_sb_if.sv
// -----------------------------------------------------------------------------
// reg_bank_sb_if
// Bundles the register bank's writeback, reservation, read-select and result
// signals.
//   master : pipeline side - drives writeEn/writeRegSel/writeData,
//            reserveEn/reserveRegSel, read1/2RegSel, read1/2Used;
//            observes regData, busy, hazardStall, sbErr.
//   slave  : the register bank - the reverse directions.
// Parameter WIDTH: register data width (regData is WIDTH*8 bits).
// -----------------------------------------------------------------------------
interface reg_bank_sb_if
  import reg_bank_sb_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) ();

  logic                      writeEn;
  logic [SEL_W-1:0]          writeRegSel;
  logic [WIDTH-1:0]          writeData;
  logic                      reserveEn;
  logic [SEL_W-1:0]          reserveRegSel;
  logic [SEL_W-1:0]          read1RegSel;
  logic [SEL_W-1:0]          read2RegSel;
  logic                      read1Used;
  logic                      read2Used;
  logic [WIDTH*NUM_REGS-1:0] regData;
  logic [NUM_REGS-1:0]       busy;
  logic                      hazardStall;
  logic                      sbErr;

  modport master (
    output writeEn, writeRegSel, writeData,
    output reserveEn, reserveRegSel,
    output read1RegSel, read2RegSel, read1Used, read2Used,
    input  regData, busy, hazardStall, sbErr
  );

  modport slave (
    input  writeEn, writeRegSel, writeData,
    input  reserveEn, reserveRegSel,
    input  read1RegSel, read2RegSel, read1Used, read2Used,
    output regData, busy, hazardStall, sbErr
  );

endinterface : reg_bank_sb_if

// File: rtl/reg_bank_sb_pend_counter.sv
// -----------------------------------------------------------------------------
// reg_pend_counter
// Pending-write counter for one register. A reservation increments, a
// writeback decrements, both or neither hold. Saturates at 2^CNT_W-1 and at 0;
// the attempted step past either bound produces a one-cycle error pulse.
// Ports:
//   clk, rst_n   clock / asynchronous active-low reset
//   i_inc        reservation for this register this cycle
//   i_dec        writeback to this register this cycle
//   o_count      current (registered) count
//   o_nonzero    count != 0
//   o_ovf        reservation attempted at max without matching write
//   o_unf        writeback attempted at zero without matching reserve
// -----------------------------------------------------------------------------
module reg_pend_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_count,
  output logic             o_nonzero,
  output logic             o_ovf,
  output logic             o_unf
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_next;
  logic             w_ovf;
  logic             w_unf;

  // Next count and bound-violation pulses.
  always_comb begin
    w_next = r_count;
    w_ovf  = 1'b0;
    w_unf  = 1'b0;
    case ({i_inc, i_dec})
      2'b10: begin
        if (r_count == CNT_MAX) begin
          w_ovf = 1'b1;
        end else begin
          w_next = r_count + CNT_ONE;
        end
      end
      2'b01: begin
        if (r_count == CNT_ZERO) begin
          w_unf = 1'b1;
        end else begin
          w_next = r_count - CNT_ONE;
        end
      end
      default: begin
        w_next = r_count;
      end
    endcase
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= CNT_ZERO;
    end else begin
      r_count <= w_next;
    end
  end

  assign o_count   = r_count;
  assign o_nonzero = (r_count != CNT_ZERO);
  assign o_ovf     = w_ovf;
  assign o_unf     = w_unf;

endmodule : reg_pend_counter

// File: rtl/reg_bank_sb.sv
// -----------------------------------------------------------------------------
// reg_bank_sb
// Eight-entry architectural register file with a per-register pending-write
// scoreboard. One writeback per cycle; decode reserves destinations; the bank
// raises hazardStall when a used source operand still has a write in flight.
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   bus     reg_bank_sb_if.slave - write/reserve/read-select inputs,
//           regData (packed, reg n at [WIDTH*(n+1)-1:WIDTH*n]), busy,
//           hazardStall, sbErr (sticky until reset)
// Optional feature: define REGBANK_WRITE_BYPASS_EN for write-before-read -
//   the slice being written shows writeData in the write cycle, and the final
//   pending write landing this cycle no longer stalls a reader.
// -----------------------------------------------------------------------------
module reg_bank_sb
  import reg_bank_sb_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  reg_bank_sb_if.slave bus
);

`ifdef REGBANK_WRITE_BYPASS_EN
  localparam logic BYPASS_EN = 1'b1;
`else
  localparam logic BYPASS_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [WIDTH-1:0]          r_regs [NUM_REGS];
  logic                      r_sb_err;
  logic [NUM_REGS-1:0]       w_wr_dec;
  logic [NUM_REGS-1:0]       w_rsv_dec;
  logic [CNT_W-1:0]          w_cnt  [NUM_REGS];
  logic [NUM_REGS-1:0]       w_nz;
  logic [NUM_REGS-1:0]       w_ovf;
  logic [NUM_REGS-1:0]       w_unf;
  logic [NUM_REGS-1:0]       w_pend;
  logic [WIDTH*NUM_REGS-1:0] w_reg_data;
  logic                      w_stall;

  assign w_wr_dec  = bus.writeEn   ? sel_decode(bus.writeRegSel)   : {NUM_REGS{1'b0}};
  assign w_rsv_dec = bus.reserveEn ? sel_decode(bus.reserveRegSel) : {NUM_REGS{1'b0}};

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_cnt
    reg_pend_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_inc     (w_rsv_dec[g]),
      .i_dec     (w_wr_dec[g]),
      .o_count   (w_cnt[g]),
      .o_nonzero (w_nz[g]),
      .o_ovf     (w_ovf[g]),
      .o_unf     (w_unf[g])
    );
  end

  // Register storage: one writeback per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= {WIDTH{1'b0}};
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_wr_dec[i]) begin
          r_regs[i] <= bus.writeData;
        end else begin
          r_regs[i] <= r_regs[i];
        end
      end
    end
  end

  // Sticky scoreboard error: any counter over/underflow attempt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sb_err <= 1'b0;
    end else begin
      r_sb_err <= r_sb_err | (|w_ovf) | (|w_unf);
    end
  end

  // Packed read bus, optionally forwarding the in-progress write.
  always_comb begin
    w_reg_data = {(WIDTH*NUM_REGS){1'b0}};
    for (int i = 0; i < NUM_REGS; i++) begin
`ifdef REGBANK_WRITE_BYPASS_EN
      if (w_wr_dec[i]) begin
        w_reg_data[i*WIDTH +: WIDTH] = bus.writeData;
      end else begin
        w_reg_data[i*WIDTH +: WIDTH] = r_regs[i];
      end
`else
      w_reg_data[i*WIDTH +: WIDTH] = r_regs[i];
`endif
    end
  end

  // Pending view used for stalls. With bypass, the last outstanding write
  // arriving this cycle is forwarded, so that register is no longer pending.
  always_comb begin
    w_pend = {NUM_REGS{1'b0}};
    for (int i = 0; i < NUM_REGS; i++) begin
      w_pend[i] = w_nz[i] & ~(BYPASS_EN & w_wr_dec[i] & (w_cnt[i] == CNT_ONE));
    end
  end

  // Stall only for operands the instruction actually reads. A same-cycle
  // reservation is not yet in w_nz, so it never stalls its own instruction.
  always_comb begin
    w_stall = (bus.read1Used & w_pend[bus.read1RegSel]) |
              (bus.read2Used & w_pend[bus.read2RegSel]);
  end

  assign bus.regData     = w_reg_data;
  assign bus.busy        = w_nz;
  assign bus.hazardStall = w_stall;
  assign bus.sbErr       = r_sb_err;

endmodule : reg_bank_sb
